// File: rtl/csr_commit_seq_pkg.sv
// Shared types for the CSR commit sequencer and its neighbours.
//   csr_kind_e : class of micro-op handled by the sequencer
//   csr_op_e   : CSR file access operation (READ/WRITE/SET/CLEAR)
//   csr_set_t  : {csr_enable, csr_op} command to the CSR file
//   *_ADDR_DEF : machine-mode addresses used for trap entry/return targets
package csr_commit_seq_pkg;

    typedef enum logic [1:0] {
        KIND_CSR   = 2'd0,
        KIND_ECALL = 2'd1,
        KIND_MRET  = 2'd2
    } csr_kind_e;

    typedef enum logic [1:0] {
        CSR_READ  = 2'd0,
        CSR_WRITE = 2'd1,
        CSR_SET   = 2'd2,
        CSR_CLEAR = 2'd3
    } csr_op_e;

    typedef struct packed {
        logic    csr_enable;
        csr_op_e csr_op;
    } csr_set_t;

    localparam logic [11:0] CSR_MTVEC_ADDR_DEF = 12'h305;
    localparam logic [11:0] CSR_MEPC_ADDR_DEF  = 12'h341;

endpackage

// File: rtl/csr_commit_seq.sv
// CSR commit sequencer. Holds one CSR/ECALL/MRET micro-op until it is at the
// ROB head, then performs the single CSR file access (CSR ops) or the trap
// entry/return (ECALL/MRET) with a front-end redirect.
// Ports:
//   clock, reset                  : clock, synchronous active-high reset
//   req_*                         : op from issue, valid/ready handshake
//   head_valid, head_tag          : current ROB head
//   flush                         : squash; drops an op still waiting for head
//   csr_set, csr_name, csr_wdata,
//   csr_pc, ecall, mret, csr_rdata: CSR file access port
//   wb_*                          : old CSR value onto the CDB (CSR ops only)
//   redirect_valid, redirect_pc   : trap / return redirect (retires the op)
//   busy                          : an op is in flight
module csr_commit_seq
    import csr_commit_seq_pkg::*;
#(
    parameter int          TAG_W          = 5,
    parameter logic [11:0] CSR_MTVEC_ADDR = CSR_MTVEC_ADDR_DEF,
    parameter logic [11:0] CSR_MEPC_ADDR  = CSR_MEPC_ADDR_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  csr_kind_e        req_kind,
    input  logic [TAG_W-1:0] req_tag,
    input  csr_op_e          req_csr_op,
    input  logic [11:0]      req_csr_name,
    input  logic [31:0]      req_wdata,
    input  logic             req_no_write,
    input  logic [31:0]      req_pc,
    input  logic             head_valid,
    input  logic [TAG_W-1:0] head_tag,
    input  logic             flush,
    output csr_set_t         csr_set,
    output logic [11:0]      csr_name,
    output logic [31:0]      csr_wdata,
    output logic [31:0]      csr_pc,
    output logic             ecall,
    output logic             mret,
    input  logic [31:0]      csr_rdata,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_tag,
    output logic [31:0]      wb_data,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             busy
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WAIT_HEAD = 3'd1;
    localparam logic [2:0] EXEC      = 3'd2;
    localparam logic [2:0] WB        = 3'd3;
    localparam logic [2:0] TRAP      = 3'd4;

    logic [2:0]       state;
    logic [TAG_W-1:0] tag_q;
    csr_kind_e        kind_q;
    csr_op_e          op_q;
    logic [11:0]      name_q;
    logic [31:0]      wdata_q;
    logic             no_write_q;
    logic [31:0]      pc_q;
    logic [31:0]      wb_data_q;

    logic head_match;
    logic in_exec;
    logic in_trap;

    assign head_match = head_valid && (head_tag == tag_q);

    // Side-effect strobes are masked while reset is high so an op caught in
    // EXEC or TRAP by a synchronous reset never touches the CSR file.
    assign in_exec = (state == EXEC) && !reset;
    assign in_trap = (state == TRAP) && !reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            tag_q      <= '0;
            kind_q     <= KIND_CSR;
            op_q       <= CSR_READ;
            name_q     <= '0;
            wdata_q    <= '0;
            no_write_q <= 1'b0;
            pc_q       <= '0;
            wb_data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        tag_q      <= req_tag;
                        kind_q     <= req_kind;
                        op_q       <= req_csr_op;
                        name_q     <= req_csr_name;
                        wdata_q    <= req_wdata;
                        no_write_q <= req_no_write;
                        pc_q       <= req_pc;
                        state      <= WAIT_HEAD;
                    end
                end
                WAIT_HEAD: begin
                    // Still speculative here, so a flush wins over reaching head.
                    // An undefined kind is dropped rather than executed.
                    if (flush) begin
                        state <= IDLE;
                    end else if (head_match) begin
                        case (kind_q)
                            KIND_CSR:   state <= EXEC;
                            KIND_ECALL: state <= TRAP;
                            KIND_MRET:  state <= TRAP;
                            default:    state <= IDLE;
                        endcase
                    end
                end
                EXEC: begin
                    wb_data_q <= csr_rdata;
                    state     <= WB;
                end
                WB: begin
                    if (wb_ready) begin
                        state <= IDLE;
                    end
                end
                TRAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The CSR address follows the latched op except during TRAP, where the
    // trap target register is read instead.
    always_comb begin
        csr_set.csr_enable = in_exec;
        csr_set.csr_op     = CSR_READ;
        if (in_exec && !no_write_q) begin
            csr_set.csr_op = op_q;
        end

        csr_name = name_q;
        if (state == TRAP) begin
            csr_name = (kind_q == KIND_ECALL) ? CSR_MTVEC_ADDR : CSR_MEPC_ADDR;
        end

        ecall          = in_trap && (kind_q == KIND_ECALL);
        mret           = in_trap && (kind_q == KIND_MRET);
        redirect_valid = in_trap;
        redirect_pc    = in_trap ? csr_rdata : 32'd0;
    end

    assign csr_wdata = wdata_q;
    assign csr_pc    = pc_q;
    assign req_ready = (state == IDLE) && !flush;
    assign busy      = (state != IDLE);
    assign wb_valid  = (state == WB) && !reset;
    assign wb_tag    = tag_q;
    assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_csr_commit_seq.sv
// Self-checking bench for csr_commit_seq. A small behavioural CSR file
// (mstatus, mcycle, mtvec, mepc, mcause) answers the access port; expected
// CDB results and redirect targets are queued when an op is issued and
// compared when the sequencer presents them.
module tb_csr_commit_seq;
    import csr_commit_seq_pkg::*;

    localparam int TAG_W = 5;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    csr_kind_e        req_kind = KIND_CSR;
    logic [TAG_W-1:0] req_tag = '0;
    csr_op_e          req_csr_op = CSR_READ;
    logic [11:0]      req_csr_name = '0;
    logic [31:0]      req_wdata = '0;
    logic             req_no_write = 1'b0;
    logic [31:0]      req_pc = '0;
    logic             head_valid = 1'b0;
    logic [TAG_W-1:0] head_tag = '0;
    logic             flush = 1'b0;
    csr_set_t         csr_set;
    logic [11:0]      csr_name;
    logic [31:0]      csr_wdata;
    logic [31:0]      csr_pc;
    logic             ecall;
    logic             mret;
    logic [31:0]      csr_rdata;
    logic             wb_valid;
    logic             wb_ready = 1'b0;
    logic [TAG_W-1:0] wb_tag;
    logic [31:0]      wb_data;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             busy;

    int tests_run = 0;
    int tests_failed = 0;

    csr_commit_seq #(.TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_tag(req_tag), .req_csr_op(req_csr_op), .req_csr_name(req_csr_name),
        .req_wdata(req_wdata), .req_no_write(req_no_write), .req_pc(req_pc),
        .head_valid(head_valid), .head_tag(head_tag), .flush(flush),
        .csr_set(csr_set), .csr_name(csr_name), .csr_wdata(csr_wdata),
        .csr_pc(csr_pc), .ecall(ecall), .mret(mret), .csr_rdata(csr_rdata),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
        .wb_data(wb_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 clock = ~clock;

    // Behavioural CSR file
    logic [31:0] m_mstatus = 32'h0000_1800;
    logic [31:0] m_mcycle  = 32'h0000_4321;
    logic [31:0] m_mtvec   = 32'h8000_0100;
    logic [31:0] m_mepc    = 32'h8000_0044;
    logic [31:0] m_mcause  = 32'h0;

    function automatic logic [31:0] apply_op(input csr_op_e op, input logic [31:0] old,
                                             input logic [31:0] wd);
        case (op)
            CSR_WRITE: return wd;
            CSR_SET:   return old | wd;
            CSR_CLEAR: return old & ~wd;
            default:   return old;
        endcase
    endfunction

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_name)
            12'h300: csr_rdata = m_mstatus;
            12'hB00: csr_rdata = m_mcycle;
            12'h305: csr_rdata = m_mtvec;
            12'h341: csr_rdata = m_mepc;
            12'h342: csr_rdata = m_mcause;
            default: csr_rdata = 32'h0;
        endcase
    end

    always @(posedge clock) begin
        if (csr_set.csr_enable) begin
            case (csr_name)
                12'h300: m_mstatus <= apply_op(csr_set.csr_op, m_mstatus, csr_wdata);
                12'hB00: m_mcycle  <= apply_op(csr_set.csr_op, m_mcycle, csr_wdata);
                12'h305: m_mtvec   <= apply_op(csr_set.csr_op, m_mtvec, csr_wdata);
                12'h341: m_mepc    <= apply_op(csr_set.csr_op, m_mepc, csr_wdata);
                12'h342: m_mcause  <= apply_op(csr_set.csr_op, m_mcause, csr_wdata);
                default: ;
            endcase
        end
        if (ecall) begin
            m_mepc   <= csr_pc;
            m_mcause <= 32'd11;
        end
    end

    // Event counters sampled mid-cycle
    int      enable_cnt = 0;
    int      ecall_cnt = 0;
    int      mret_cnt = 0;
    int      wb_cnt = 0;
    int      overlap_cnt = 0;
    csr_op_e last_op = CSR_READ;

    always @(negedge clock) begin
        if (csr_set.csr_enable) begin
            enable_cnt = enable_cnt + 1;
            last_op = csr_set.csr_op;
        end
        if (ecall) ecall_cnt = ecall_cnt + 1;
        if (mret) mret_cnt = mret_cnt + 1;
        if (wb_valid) wb_cnt = wb_cnt + 1;
        if (int'(csr_set.csr_enable && csr_set.csr_op != CSR_READ) + int'(ecall) + int'(mret) > 1)
            overlap_cnt = overlap_cnt + 1;
    end

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } wb_exp_t;

    wb_exp_t     wb_q[$];
    logic [31:0] redir_q[$];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input csr_kind_e k, input logic [TAG_W-1:0] t, input csr_op_e op,
                         input logic [11:0] nm, input logic [31:0] wd, input logic nw,
                         input logic [31:0] pc);
        int n;
        req_kind = k; req_tag = t; req_csr_op = op; req_csr_name = nm;
        req_wdata = wd; req_no_write = nw; req_pc = pc; req_valid = 1'b1;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL accept_tag%0d: req_ready=%b, expected 1", t, req_ready);
        end
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_wb(input string name);
        int n = 0;
        @(negedge clock);
        while (!wb_valid && n < 30) begin
            @(negedge clock);
            n++;
        end
        tests_run++;
        if (wb_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL %s_wb_timeout: wb_valid=%b, expected 1", name, wb_valid);
        end
    endtask

    task automatic pop_wb(input string name);
        wb_exp_t e;
        wb_ready = 1'b1;
        tests_run++;
        if (wb_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL %s_sb_empty: got wb tag %0d with no expected entry", name, wb_tag);
        end else begin
            e = wb_q.pop_front();
            if (wb_tag !== e.tag || wb_data !== e.data) begin
                tests_failed++;
                $display("[TB] FAIL %s_wb: got tag %0d data %h, expected tag %0d data %h",
                         name, wb_tag, wb_data, e.tag, e.data);
            end
        end
        step();
        wb_ready = 1'b0;
    endtask

    task automatic wait_redirect(input string name);
        int n = 0;
        logic [31:0] exp_pc;
        @(negedge clock);
        while (!redirect_valid && n < 30) begin
            @(negedge clock);
            n++;
        end
        tests_run++;
        if (redirect_valid !== 1'b1 || redir_q.size() == 0) begin
            tests_failed++;
            $display("[TB] FAIL %s_redirect_timeout: redirect_valid=%b, expected 1", name, redirect_valid);
        end else begin
            exp_pc = redir_q.pop_front();
            if (redirect_pc !== exp_pc) begin
                tests_failed++;
                $display("[TB] FAIL %s_redirect_pc: got %h, expected %h", name, redirect_pc, exp_pc);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step(); step();
        reset = 1'b0;
        @(negedge clock);
        tests_run++;
        if ({req_ready, busy, wb_valid, redirect_valid, csr_set.csr_enable, ecall, mret} !== 7'b1000000) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got %b, expected 1000000",
                     {req_ready, busy, wb_valid, redirect_valid, csr_set.csr_enable, ecall, mret});
        end
        tests_run++;
        if (wb_tag !== '0 || wb_data !== 32'h0 || redirect_pc !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_wb: got tag %0d data %h rpc %h, expected zeros", wb_tag, wb_data, redirect_pc);
        end
        tests_run++;
        if (csr_name !== 12'h0 || csr_wdata !== 32'h0 || csr_pc !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_csr_port: got name %h wdata %h pc %h, expected zeros", csr_name, csr_wdata, csr_pc);
        end
        step();
    endtask

    task automatic test_csrrw();
        int e0 = enable_cnt;
        wb_q.push_back('{tag: 5'd3, data: 32'h0000_1800});
        issue(KIND_CSR, 5'd3, CSR_WRITE, 12'h300, 32'h0000_1888, 1'b0, 32'h8000_0000);
        head_valid = 1'b1;
        head_tag = 5'd1;
        for (int i = 0; i < 4; i++) step();
        tests_run++;
        if (enable_cnt != e0 || busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL csrrw_hold: enables %0d busy %b, expected 0 enables busy 1", enable_cnt - e0, busy);
        end
        head_tag = 5'd3;
        wait_wb("csrrw");
        tests_run++;
        if (enable_cnt - e0 != 1 || last_op !== CSR_WRITE) begin
            tests_failed++;
            $display("[TB] FAIL csrrw_enable: got %0d enables op %0d, expected 1 op %0d",
                     enable_cnt - e0, last_op, CSR_WRITE);
        end
        tests_run++;
        if (m_mstatus !== 32'h0000_1888) begin
            tests_failed++;
            $display("[TB] FAIL csrrw_mstatus: got %h, expected 00001888", m_mstatus);
        end
        pop_wb("csrrw");
        head_valid = 1'b0;
        @(negedge clock);
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL csrrw_idle: busy=%b, expected 0", busy);
        end
        step();
    endtask

    task automatic test_read_only();
        int e0 = enable_cnt;
        wb_q.push_back('{tag: 5'd4, data: 32'h0000_4321});
        issue(KIND_CSR, 5'd4, CSR_SET, 12'hB00, 32'h0000_00FF, 1'b1, 32'h8000_0004);
        head_valid = 1'b1;
        head_tag = 5'd4;
        wait_wb("read_only");
        tests_run++;
        if (enable_cnt - e0 != 1 || last_op !== CSR_READ) begin
            tests_failed++;
            $display("[TB] FAIL read_only_op: got %0d enables op %0d, expected 1 op %0d",
                     enable_cnt - e0, last_op, CSR_READ);
        end
        tests_run++;
        if (m_mcycle !== 32'h0000_4321) begin
            tests_failed++;
            $display("[TB] FAIL read_only_unchanged: mcycle %h, expected 00004321", m_mcycle);
        end
        pop_wb("read_only");
        head_valid = 1'b0;
        step();
    endtask

    task automatic test_mret();
        int w0 = wb_cnt;
        int m0 = mret_cnt;
        redir_q.push_back(32'h8000_0044);
        issue(KIND_MRET, 5'd5, CSR_READ, 12'h000, 32'h0, 1'b0, 32'h8000_0200);
        head_valid = 1'b1;
        head_tag = 5'd5;
        wait_redirect("mret");
        tests_run++;
        if (mret !== 1'b1 || ecall !== 1'b0 || csr_name !== 12'h341) begin
            tests_failed++;
            $display("[TB] FAIL mret_pulse: mret %b ecall %b name %h, expected 1 0 341", mret, ecall, csr_name);
        end
        step();
        head_valid = 1'b0;
        @(negedge clock);
        tests_run++;
        if (mret_cnt - m0 != 1 || redirect_valid !== 1'b0 || wb_cnt != w0 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mret_after: pulses %0d rv %b wbs %0d busy %b, expected 1 0 0 0",
                     mret_cnt - m0, redirect_valid, wb_cnt - w0, busy);
        end
        step();
    endtask

    task automatic test_ecall();
        int w0 = wb_cnt;
        int c0 = ecall_cnt;
        redir_q.push_back(32'h8000_0100);
        issue(KIND_ECALL, 5'd6, CSR_READ, 12'h000, 32'h0, 1'b0, 32'h8000_0040);
        head_valid = 1'b1;
        head_tag = 5'd2;
        step(); step();
        head_tag = 5'd6;
        wait_redirect("ecall");
        tests_run++;
        if (ecall !== 1'b1 || mret !== 1'b0 || csr_name !== 12'h305 || csr_pc !== 32'h8000_0040) begin
            tests_failed++;
            $display("[TB] FAIL ecall_pulse: ecall %b mret %b name %h pc %h, expected 1 0 305 80000040",
                     ecall, mret, csr_name, csr_pc);
        end
        step();
        head_valid = 1'b0;
        @(negedge clock);
        tests_run++;
        if (ecall_cnt - c0 != 1 || ecall !== 1'b0 || wb_cnt != w0) begin
            tests_failed++;
            $display("[TB] FAIL ecall_once: pulses %0d ecall %b wbs %0d, expected 1 0 0",
                     ecall_cnt - c0, ecall, wb_cnt - w0);
        end
        tests_run++;
        if (m_mepc !== 32'h8000_0040 || m_mcause !== 32'd11 || m_mtvec !== 32'h8000_0100) begin
            tests_failed++;
            $display("[TB] FAIL ecall_csrs: mepc %h mcause %h mtvec %h, expected 80000040 0000000b 80000100",
                     m_mepc, m_mcause, m_mtvec);
        end
        step();
    endtask

    task automatic test_flush();
        int e0 = enable_cnt;
        int c0 = ecall_cnt;
        int m0 = mret_cnt;
        issue(KIND_CSR, 5'd7, CSR_WRITE, 12'h300, 32'h0, 1'b0, 32'h8000_0008);
        flush = 1'b1;
        @(negedge clock);
        tests_run++;
        if (req_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_ready_low: req_ready=%b, expected 0", req_ready);
        end
        step();
        flush = 1'b0;
        @(negedge clock);
        tests_run++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_idle: req_ready %b busy %b, expected 1 0", req_ready, busy);
        end
        step();
        head_valid = 1'b1;
        head_tag = 5'd7;
        step(); step(); step();
        head_valid = 1'b0;
        tests_run++;
        if (enable_cnt != e0 || ecall_cnt != c0 || mret_cnt != m0 || m_mstatus !== 32'h0000_1888) begin
            tests_failed++;
            $display("[TB] FAIL flush_no_effect: enables %0d ecalls %0d mrets %0d mstatus %h, expected 0 0 0 00001888",
                     enable_cnt - e0, ecall_cnt - c0, mret_cnt - m0, m_mstatus);
        end
    endtask

    task automatic test_back_to_back();
        wb_q.push_back('{tag: 5'd9, data: 32'h0000_1888});
        issue(KIND_CSR, 5'd9, CSR_CLEAR, 12'h300, 32'h0000_0008, 1'b0, 32'h8000_0010);
        head_valid = 1'b1;
        head_tag = 5'd9;
        wait_wb("stall");
        // Next op offered while the CDB is stalled
        req_kind = KIND_CSR; req_tag = 5'd10; req_csr_op = CSR_READ; req_csr_name = 12'h300;
        req_wdata = 32'h0; req_no_write = 1'b0; req_pc = 32'h8000_0014; req_valid = 1'b1;
        wb_q.push_back('{tag: 5'd10, data: 32'h0000_1880});
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (wb_valid !== 1'b1 || wb_tag !== wb_q[0].tag || wb_data !== wb_q[0].data || req_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL stall_hold%0d: valid %b tag %0d data %h ready %b, expected 1 %0d %h 0",
                         i, wb_valid, wb_tag, wb_data, req_ready, wb_q[0].tag, wb_q[0].data);
            end
            @(negedge clock);
        end
        tests_run++;
        if (req_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stall_ready_on_wb: req_ready=%b, expected 0", req_ready);
        end
        pop_wb("stall");
        @(negedge clock);
        tests_run++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_gap: req_ready %b busy %b, expected 1 0", req_ready, busy);
        end
        step();
        req_valid = 1'b0;
        @(negedge clock);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL b2b_accept: busy=%b, expected 1", busy);
        end
        head_tag = 5'd10;
        wait_wb("b2b");
        pop_wb("b2b");
        head_valid = 1'b0;
        tests_run++;
        if (m_mstatus !== 32'h0000_1880) begin
            tests_failed++;
            $display("[TB] FAIL b2b_mstatus: got %h, expected 00001880", m_mstatus);
        end
        step();
    endtask

    task automatic test_reset_abort();
        int e0 = enable_cnt;
        issue(KIND_CSR, 5'd12, CSR_WRITE, 12'h300, 32'hDEAD_0000, 1'b0, 32'h8000_0020);
        head_valid = 1'b1;
        head_tag = 5'd12;
        step();
        reset = 1'b1;
        @(negedge clock);
        tests_run++;
        if (csr_set.csr_enable !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_enable: csr_enable=%b, expected 0", csr_set.csr_enable);
        end
        step();
        reset = 1'b0;
        head_valid = 1'b0;
        @(negedge clock);
        tests_run++;
        if (busy !== 1'b0 || wb_valid !== 1'b0 || wb_data !== 32'h0 || enable_cnt != e0 ||
            m_mstatus !== 32'h0000_1880) begin
            tests_failed++;
            $display("[TB] FAIL abort_state: busy %b wbv %b wbd %h enables %0d mstatus %h, expected 0 0 0 0 00001880",
                     busy, wb_valid, wb_data, enable_cnt - e0, m_mstatus);
        end
        step();
    endtask

    task automatic test_exclusive();
        tests_run++;
        if (overlap_cnt != 0) begin
            tests_failed++;
            $display("[TB] FAIL exclusive_side_effects: %0d overlapping cycles, expected 0", overlap_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_csrrw();
        test_read_only();
        test_mret();
        test_ecall();
        test_flush();
        test_back_to_back();
        test_reset_abort();
        test_exclusive();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
